cpu_mem_arbiter: RTL and testbench
==================================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have params: MAX_OUTSTANDING=2 (response-order FIFO depth); STARVE_LIMIT=4 (consecutive data grants before a forced inst grant).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; resetn  in  1  synchronous, active-low reset.
REQ-003 SHALL have inst-side ports: inst_req in 1; inst_addr in 32; inst_size in 2; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out 32.
REQ-004 SHALL have data-side ports: data_req in 1; data_wr in 1; data_size in 2; data_wstrb in 4; data_addr in 32; data_wdata in 32; data_addr_ok out 1; data_data_ok out 1; data_rdata out 32.
REQ-005 SHALL have memory-side ports: mem_req out 1; mem_wr out 1; mem_size out 2; mem_wstrb out 4; mem_addr out 32; mem_wdata out 32; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in 32.
REQ-006 SHALL have status ports: outstanding out 2 (accepted, unanswered count); resp_err out 1 (sticky unexpected-response flag).

Function
REQ-007 SHALL use FSM states IDLE, LOCK_I, LOCK_D; LOCK_x means the grant is held for source x.
REQ-008 IDLE: if FIFO not full and a request is pending, SHALL enter LOCK_D if data_req and not starve_force, else LOCK_I if inst_req; otherwise stay IDLE.
REQ-009 starve_force SHALL be 1 when starve_cnt == STARVE_LIMIT and inst_req=1.
REQ-010 In LOCK_x, mem_req SHALL equal the granted source's req; mem_* fields SHALL be muxed combinationally from that source.
REQ-011 For an inst grant, mem_wr SHALL be 0 and mem_wstrb 4'b0000.
REQ-012 Outside LOCK states, mem_req SHALL be 0.
REQ-013 Handshake: the granted source's addr_ok SHALL equal mem_addr_ok & mem_req; the ungranted source's addr_ok SHALL be 0.
REQ-014 On an addr handshake (mem_req & mem_addr_ok), the FSM SHALL return to IDLE the next cycle, and the source id (0=inst, 1=data) SHALL be pushed to the order FIFO.
REQ-015 A grant SHALL NOT switch source mid-handshake; if the granted req drops before addr_ok, the FSM SHALL return to IDLE with nothing pushed.
REQ-016 Response routing: on mem_data_ok with FIFO non-empty, the head id SHALL select inst_data_ok or data_data_ok for that cycle, and the head SHALL be popped.
REQ-017 inst_rdata and data_rdata SHALL both be driven with mem_rdata combinationally.
REQ-018 mem_data_ok while FIFO empty SHALL be ignored for routing and SHALL set resp_err=1 until reset.
REQ-019 Same-cycle push and pop SHALL both occur; outstanding stays unchanged.
REQ-020 Same-cycle push and pop with a full FIFO SHALL still accept the push.
REQ-021 Full FIFO without a same-cycle pop: no new grant SHALL be issued from IDLE.
REQ-022 starve_cnt (3 bits, saturating at STARVE_LIMIT) SHALL increment on each data handshake while inst_req=1.
REQ-023 starve_cnt SHALL clear on any inst handshake, or on any cycle with inst_req=0.
REQ-024 Pointers SHALL wrap modulo MAX_OUTSTANDING; outstanding SHALL be registered.
REQ-025 Arbitration latency: IDLE->LOCK takes 1 cycle; the earliest mem_req is the cycle after the source asserts req.

Reset
REQ-026 With resetn=0 at a clock edge, the FSM SHALL go to IDLE and FIFO pointers, outstanding, starve_cnt and resp_err SHALL clear to 0.
REQ-027 All handshake outputs SHALL be 0 while in reset.
REQ-028 Reset mid-transaction SHALL drop all outstanding ids with no response routing afterwards.

Structure
REQ-029 Source-id encoding, FSM state encodings and parameter defaults SHALL live in the shared CPU package.
REQ-030 The order FIFO SHALL be a sub-module, resp_order_fifo (1-bit data, DEPTH=MAX_OUTSTANDING).

Verification
REQ-031 Data and inst requests both asserted from reset with mem_addr_ok=1 -> data granted first (data_addr_ok at cycle 2), inst granted at the next IDLE pass.
REQ-032 data_req held high for 6 requests with inst_req high -> 5th grant goes to inst; starve_cnt returns to 0.
REQ-033 Inst read then data read accepted, then mem_data_ok twice with rdata 0x11111111 and 0x22222222 -> inst_data_ok gets 0x11111111, then data_data_ok gets 0x22222222.
REQ-034 Two accepts with no data_ok -> outstanding=2 and mem_req stays 0; one mem_data_ok -> outstanding=1, and the next grant occurs.
REQ-035 mem_data_ok pulsed with outstanding=0 -> no *_data_ok asserted; resp_err=1, held until resetn=0.
REQ-036 resetn low for one cycle while outstanding=2 -> outstanding=0, FSM IDLE; a later mem_data_ok sets resp_err.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU instruction/data memory arbiter.
package cpu_mem_arbiter_pkg;

    // Parameter defaults
    localparam int MAX_OUTSTANDING_DEF = 2;
    localparam int STARVE_LIMIT_DEF    = 4;

    // Source id stored in the response-order FIFO
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // Arbiter FSM: LOCK_x holds the memory port for source x until its
    // address handshake completes or its request is withdrawn.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cpu_mem_arbiter_fifo.sv
// Response-order FIFO: remembers which source owns each accepted request so
// in-order memory responses can be routed back to the right port.
module resp_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  logic                         push_id,
    input  logic                         pop,
    output logic                         head_id,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // take a push when it is also being popped.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = ids[rd_ptr];

    // Pointer and occupancy tracking, wrapping modulo DEPTH
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Id storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push_ok)
            ids[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates an instruction port and a data port onto a single memory port.
// Data has priority unless the instruction side has been starved.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction side
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // memory side
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    // status
    output logic [1:0]  outstanding,
    output logic        resp_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t      state, next_state;
    logic [2:0]      starve_cnt;
    logic            starve_force;
    logic            hs, pop, grant_ok;
    logic            fifo_full, fifo_empty, head_id;
    logic [CW-1:0]   fifo_count;

    assign starve_force = (starve_cnt == 3'(STARVE_LIMIT)) & inst_req;
    assign hs           = mem_req & mem_addr_ok;
    assign pop          = mem_data_ok & ~fifo_empty & resetn;
    assign grant_ok     = ~fifo_full | pop;

    assign inst_addr_ok = hs & (state == LOCK_I);
    assign data_addr_ok = hs & (state == LOCK_D);
    assign inst_data_ok = pop & (head_id == SRC_INST);
    assign data_data_ok = pop & (head_id == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign outstanding  = 2'(fifo_count);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state and memory-port mux; a lock ends on handshake or withdrawn req
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = 2'b00;
        mem_wstrb  = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    if (data_req && !starve_force) next_state = LOCK_D;
                    else if (inst_req)             next_state = LOCK_I;
                end
            end
            LOCK_I: begin
                mem_req  = inst_req & resetn;
                mem_size = inst_size;
                mem_addr = inst_addr;
                if (!inst_req || mem_addr_ok) next_state = IDLE;
            end
            LOCK_D: begin
                mem_req   = data_req & resetn;
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
                if (!data_req || mem_addr_ok) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Starvation counter: counts data grants taken while inst is waiting
    always_ff @(posedge clk) begin
        if (!resetn || !inst_req || inst_addr_ok)
            starve_cnt <= '0;
        else if (data_addr_ok && starve_cnt < 3'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 3'd1;
    end

    // Sticky flag for a memory response with nothing outstanding
    always_ff @(posedge clk) begin
        if (!resetn)                        resp_err <= 1'b0;
        else if (mem_data_ok && fifo_empty) resp_err <= 1'b1;
    end

    resp_order_fifo #(.DEPTH(MAX_OUTSTANDING)) u_order (
        .clk     (clk),
        .resetn  (resetn),
        .push    (hs),
        .push_id ((state == LOCK_D) ? SRC_DATA : SRC_INST),
        .pop     (pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: priority, ordering, back-pressure,
// starvation, spurious responses and reset behaviour.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    logic        clk, resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [1:0]  outstanding;
    logic        resp_err;

    int n_cmp = 0;
    int n_err = 0;

    cpu_mem_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs;
        inst_req = 0; inst_addr = '0; inst_size = 2'd2;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    // One reset cycle; returns just after release at a negedge
    task automatic apply_reset;
        @(negedge clk);
        resetn = 0;
        clear_inputs();
        @(negedge clk);
        resetn = 1;
    endtask

    task automatic test_reset;
        resetn = 0;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
        n_cmp++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
            n_err++; $display("FAIL rst_handshakes: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        n_cmp++; if (outstanding !== 2'd0) begin n_err++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %0b want 0", resp_err); end
        clear_inputs();
        @(negedge clk);
        resetn = 1;
    endtask

    // Both requests from reset: data first at cycle 2, inst on the next IDLE pass
    task automatic test_priority;
        apply_reset();
        inst_req = 1; inst_addr = 32'h0000_0200;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h0000_0100; data_wdata = 32'hCAFE_F00D;
        mem_addr_ok = 1;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL prio_latency: mem_req got %0b want 0", mem_req); end
        @(negedge clk); #1;
        n_cmp++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin n_err++; $display("FAIL prio_data_first: d/i addr_ok got %b want 10", {data_addr_ok, inst_addr_ok}); end
        n_cmp++; if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL prio_data_fields: wr=%0b wstrb=%h addr=%h wdata=%h want 1 f 00000100 cafef00d", mem_wr, mem_wstrb, mem_addr, mem_wdata); end
        @(negedge clk);
        data_req = 0;
        @(negedge clk); #1;
        n_cmp++; if ({inst_addr_ok, mem_wr, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h0000_0200}) begin
            n_err++; $display("FAIL prio_inst_grant: aok=%0b wr=%0b wstrb=%h addr=%h want 1 0 0 00000200", inst_addr_ok, mem_wr, mem_wstrb, mem_addr); end
        n_cmp++; if (outstanding !== 2'd1) begin n_err++; $display("FAIL prio_outst1: got %0d want 1", outstanding); end
        @(negedge clk);
        inst_req = 0; #1;
        n_cmp++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL prio_outst2: got %0d want 2", outstanding); end
    endtask

    // Inst then data accepted; responses routed in acceptance order
    task automatic test_order;
        apply_reset();
        inst_req = 1; mem_addr_ok = 1;
        @(negedge clk); #1;
        n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL order_inst_aok: got %0b want 1", inst_addr_ok); end
        @(negedge clk);
        inst_req = 0; data_req = 1; data_wr = 0;
        @(negedge clk); #1;
        n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++; $display("FAIL order_data_aok: got %0b want 1", data_addr_ok); end
        @(negedge clk);
        data_req = 0; mem_data_ok = 1; mem_rdata = 32'h1111_1111; #1;
        n_cmp++; if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h1111_1111}) begin
            n_err++; $display("FAIL order_resp1: i/d data_ok=%b rdata=%h want 10 11111111", {inst_data_ok, data_data_ok}, inst_rdata); end
        @(negedge clk);
        mem_rdata = 32'h2222_2222; #1;
        n_cmp++; if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, 32'h2222_2222}) begin
            n_err++; $display("FAIL order_resp2: i/d data_ok=%b rdata=%h want 01 22222222", {inst_data_ok, data_data_ok}, data_rdata); end
        @(negedge clk);
        mem_data_ok = 0; #1;
        n_cmp++; if ({outstanding, resp_err} !== 3'b000) begin n_err++; $display("FAIL order_drained: outst=%0d err=%0b want 0 0", outstanding, resp_err); end
    endtask

    // Full FIFO blocks grants; a pop re-enables them; a withdrawn req pushes nothing
    task automatic test_full;
        apply_reset();
        inst_req = 1; mem_addr_ok = 1;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if ({outstanding, mem_req} !== 3'b100) begin n_err++; $display("FAIL full_stall: outst=%0d mem_req=%0b want 2 0", outstanding, mem_req); end
        @(negedge clk); #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_hold: mem_req got %0b want 0", mem_req); end
        mem_data_ok = 1; #1;
        n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL full_pop: inst_data_ok got %0b want 1", inst_data_ok); end
        @(negedge clk);
        mem_data_ok = 0; #1;
        n_cmp++; if ({outstanding, inst_addr_ok} !== 3'b011) begin n_err++; $display("FAIL full_regrant: outst=%0d aok=%0b want 1 1", outstanding, inst_addr_ok); end
        inst_req = 0; #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_withdraw: mem_req got %0b want 0", mem_req); end
        @(negedge clk); #1;
        n_cmp++; if (outstanding !== 2'd1 || dut.state !== IDLE) begin
            n_err++; $display("FAIL full_nopush: outst=%0d state=%0d want 1 0", outstanding, dut.state); end
    endtask

    // Data held high with inst waiting: 5th grant forced to inst
    task automatic test_starve;
        int         grants;
        logic [5:0] got;
        logic       hs_prev, chk_cnt;
        apply_reset();
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        grants = 0; got = '0; hs_prev = 0; chk_cnt = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            @(negedge clk);
            mem_data_ok = hs_prev; #1;
            if (chk_cnt) begin
                chk_cnt = 0;
                n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_err++; $display("FAIL starve_clear: cnt got %0d want 0", dut.starve_cnt); end
            end
            hs_prev = mem_req & mem_addr_ok;
            if (inst_addr_ok) begin
                got[grants] = 1'b1;
                if (grants == 4) chk_cnt = 1;
                grants++;
            end else if (data_addr_ok) begin
                got[grants] = 1'b0;
                grants++;
            end
        end
        inst_req = 0; data_req = 0; mem_data_ok = 0;
        n_cmp++; if (grants != 6) begin n_err++; $display("FAIL starve_timeout: grants got %0d want 6", grants); end
        n_cmp++; if (got !== 6'b010000) begin n_err++; $display("FAIL starve_seq: got %b want 010000 (bit=grant, 1=inst)", got); end
    endtask

    // Response with nothing outstanding: ignored, sticky error until reset
    task automatic test_spurious;
        apply_reset();
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL spur_route: got %b want 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        mem_data_ok = 0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL spur_sticky: got %0b want 1", resp_err); end
        resetn = 0;
        @(negedge clk); #1;
        n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL spur_reset: got %0b want 0", resp_err); end
        resetn = 1;
    endtask

    // Reset with two ids in flight drops them; a later response is an error
    task automatic test_reset_mid;
        apply_reset();
        inst_req = 1; mem_addr_ok = 1;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++; if (outstanding !== 2'd2) begin n_err++; $display("FAIL rmid_setup: outst got %0d want 2", outstanding); end
        resetn = 0; mem_data_ok = 1; #1;
        n_cmp++; if ({mem_req, inst_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
            n_err++; $display("FAIL rmid_in_reset: got %b want 0000", {mem_req, inst_addr_ok, inst_data_ok, data_data_ok}); end
        @(negedge clk);
        resetn = 1; inst_req = 0; mem_data_ok = 0; #1;
        n_cmp++; if (outstanding !== 2'd0 || dut.state !== IDLE) begin
            n_err++; $display("FAIL rmid_cleared: outst=%0d state=%0d want 0 0", outstanding, dut.state); end
        @(negedge clk);
        mem_data_ok = 1; #1;
        n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL rmid_noroute: got %b want 00", {inst_data_ok, data_data_ok}); end
        @(negedge clk);
        mem_data_ok = 0; #1;
        n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL rmid_resp_err: got %0b want 1", resp_err); end
    endtask

    initial begin
        resetn = 0;
        clear_inputs();
        test_reset();
        test_priority();
        test_order();
        test_full();
        test_starve();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
